// File: rtl/ppl_key_port.sv
// Memory-mapped key/switch input port: 2-FF sync, tick-based debounce, sticky W1C
// press events and a masked interrupt flag. Optional release events: KEYPORT_RELEASE_EVT_EN.
module ppl_key_lane #(
  parameter bit INV = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  input  logic       tick,
  input  logic [7:0] thr,
  output logic       level,
  output logic       rise,
  output logic       fall
);
  logic [1:0] sync;
  logic [7:0] cnt;
  logic       s;
  logic       hit_thr;
  logic       flip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[0], key};
  end

  assign s       = sync[1] ^ INV;
  // 9-bit compare so cnt=255 cannot wrap past the threshold
  assign hit_thr = ({1'b0, cnt} + 9'd1) >= {1'b0, thr};
  assign flip    = tick && (s != level) && hit_thr;
  assign rise    = flip & s;
  assign fall    = flip & ~s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (tick) begin
      if (s == level) begin
        cnt <= '0;
      end else if (hit_thr) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

module ppl_key_port #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_00C0,
  parameter int          NKEYS     = 10,
  parameter logic [NKEYS-1:0] KEY_INV = '0,
  parameter int          TICK_DIV  = 50000,
  parameter logic [7:0]  DB_DEF    = 8'd4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] keys,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  output logic             irq
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef struct packed {
    logic       hit;
    logic [2:0] off;
    logic       wr;
  } req_t;

  req_t             req;
  logic [PW-1:0]    pre;
  logic             tick;
  logic [7:0]       cfg_q, cfg_nxt, thr_eff;
  logic [NKEYS-1:0] level, rise_v, fall_v;
  logic [NKEYS-1:0] event_q, event_nxt, mask_q, mask_nxt;
  logic [NKEYS-1:0] rel_nxt;
  logic             unused_ok;

  assign unused_ok = &{1'b0, addr[1:0], wdata, fall_v};

  assign req.hit = (addr[31:5] == BASE_ADDR[31:5]);
  assign req.off = addr[4:2];
  assign req.wr  = we & req.hit;

  // tick is registered: high for the one cycle in which the count sits at 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      pre  <= (pre == PW'(TICK_DIV - 1)) ? '0 : pre + PW'(1);
      tick <= (pre == PW'(TICK_DIV - 1));
    end
  end

  assign thr_eff = (cfg_q == 8'd0) ? 8'd1 : cfg_q;

  for (genvar i = 0; i < NKEYS; i++) begin : g_lane
    ppl_key_lane #(.INV(KEY_INV[i])) u_lane (
      .clk   (clk),
      .reset (reset),
      .key   (keys[i]),
      .tick  (tick),
      .thr   (thr_eff),
      .level (level[i]),
      .rise  (rise_v[i]),
      .fall  (fall_v[i])
    );
  end

  // set wins over a same-cycle W1C store
  always_comb begin
    event_nxt = event_q | rise_v;
    mask_nxt  = mask_q;
    cfg_nxt   = cfg_q;
    if (req.wr) begin
      case (req.off)
        3'd1:    event_nxt = (event_q & ~wdata[NKEYS-1:0]) | rise_v;
        3'd2:    mask_nxt  = wdata[NKEYS-1:0];
        3'd3:    cfg_nxt   = wdata[7:0];
        default: ;
      endcase
    end
  end

`ifdef KEYPORT_RELEASE_EVT_EN
  logic [NKEYS-1:0] rel_q;

  always_comb begin
    rel_nxt = rel_q | fall_v;
    if (req.wr && req.off == 3'd4) rel_nxt = (rel_q & ~wdata[NKEYS-1:0]) | fall_v;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rel_q <= '0;
    else        rel_q <= rel_nxt;
  end
`else
  assign rel_nxt = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      event_q <= '0;
      mask_q  <= '0;
      cfg_q   <= DB_DEF;
      irq     <= 1'b0;
    end else begin
      event_q <= event_nxt;
      mask_q  <= mask_nxt;
      cfg_q   <= cfg_nxt;
      irq     <= |((event_nxt | rel_nxt) & mask_nxt);
    end
  end

  always_comb begin
    rdata = '0;
    if (req.hit) begin
      case (req.off)
        3'd0:    rdata = {{(32-NKEYS){1'b0}}, level};
        3'd1:    rdata = {{(32-NKEYS){1'b0}}, event_q};
        3'd2:    rdata = {{(32-NKEYS){1'b0}}, mask_q};
        3'd3:    rdata = {24'd0, cfg_q};
`ifdef KEYPORT_RELEASE_EVT_EN
        3'd4:    rdata = {{(32-NKEYS){1'b0}}, rel_q};
`endif
        default: rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_ppl_key_port.sv
// Directed bench for ppl_key_port with TICK_DIV=4; covers reset, decode, debounce,
// bounce rejection, W1C set-wins, mid-count reset and the optional release register.
module tb_ppl_key_port;
  localparam logic [31:0] BASE = 32'h0000_00C0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  keys = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        irq;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  ppl_key_port #(.BASE_ADDR(BASE), .NKEYS(10), .KEY_INV(10'b0), .TICK_DIV(4), .DB_DEF(8'd4)) dut (
    .clk(clk), .reset(reset), .keys(keys), .addr(addr),
    .wdata(wdata), .we(we), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    addr = BASE + 32'(off); wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd_abs(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] d;
    rd_abs(BASE + 32'(off), d);
    chk(tag, d, exp);
  endtask

  task automatic align;
    do begin @(posedge clk); #1; end while (cyc % 4 != 0);
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    logic irq_prev, irq_land;

    cyc_wait(3);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    cyc_wait(1);
    rd_chk("rst_level", 8'h00, 32'h0);
    rd_chk("rst_event", 8'h04, 32'h0);
    rd_chk("rst_mask",  8'h08, 32'h0);
    rd_chk("rst_cfg",   8'h0C, 32'h4);
    rd_chk("undef_14",  8'h14, 32'h0);
    wr(8'h0C, 32'h4);
    rd_abs(BASE + 32'h20, d); chk("miss_20", d, 32'h0);
    rd_abs(32'h0, d);         chk("miss_00", d, 32'h0);
    rd_abs(BASE + 32'h0E, d); chk("cfg_byte_ign", d, 32'h4);

    wr(8'h0C, 32'h3);
    wr(8'h08, 32'h4);
    rd_chk("cfg_rw",  8'h0C, 32'h3);
    rd_chk("mask_rw", 8'h08, 32'h4);

    // clean press of key 2, latency measured from a fixed tick phase
    align;
    addr = BASE;
    keys[2] = 1'b1;
    lat = 0; irq_prev = 1'b0; irq_land = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (rdata[2]) begin lat = n; irq_land = irq; break; end
      irq_prev = irq;
    end
    chk("press_lat_ok", {31'd0, (lat >= 10 && lat <= 18)}, 32'd1);
    chk("irq_before", {31'd0, irq_prev}, 32'd0);
    chk("irq_after",  {31'd0, irq_land}, 32'd1);
    rd_chk("press_level", 8'h00, 32'h004);
    rd_chk("press_event", 8'h04, 32'h004);

    // second key, then W1C of one bit
    keys[0] = 1'b1;
    cyc_wait(24);
    rd_chk("ev_005", 8'h04, 32'h005);
    rd_chk("lv_005", 8'h00, 32'h005);
    wr(8'h04, 32'h001);
    rd_chk("w1c_bit0", 8'h04, 32'h004);
    chk("irq_kept", {31'd0, irq}, 32'd1);
    wr(8'h04, 32'h004);
    rd_chk("w1c_bit2", 8'h04, 32'h000);
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // bounce: 2 ticks high, 1 tick low never reaches THR=3
    for (int r = 0; r < 4; r++) begin
      keys[5] = 1'b1; cyc_wait(8);
      keys[5] = 1'b0; cyc_wait(4);
    end
    rd_chk("bounce_level", 8'h00, 32'h005);
    rd_chk("bounce_event", 8'h04, 32'h000);
    keys[5] = 1'b1;
    cyc_wait(24);
    rd_chk("held_level", 8'h00, 32'h025);
    rd_chk("held_event", 8'h04, 32'h020);
    wr(8'h04, 32'h3FF);

    // set-wins: store clearing bit 2 on the very edge the new press lands
    keys[2] = 1'b0;
    cyc_wait(30);
    rd_chk("rel_level", 8'h00, 32'h021);
    wr(8'h04, 32'h3FF);
`ifdef KEYPORT_RELEASE_EVT_EN
    wr(8'h10, 32'h3FF);
`endif
    align;
    keys[2] = 1'b1;
    cyc_wait(lat - 1);
    rd_chk("pre_land_event", 8'h04, 32'h000);
    wr(8'h04, 32'h004);
    rd_chk("set_wins", 8'h04, 32'h004);
    rd_chk("set_wins_lvl", 8'h00, 32'h025);
    wr(8'h04, 32'h004);
    rd_chk("clr_after", 8'h04, 32'h000);

    // reset in the middle of key 7's count
    keys = '0;
    cyc_wait(30);
    wr(8'h04, 32'h3FF);
`ifdef KEYPORT_RELEASE_EVT_EN
    wr(8'h10, 32'h3FF);
`endif
    align;
    keys[7] = 1'b1;
    cyc_wait(lat - 3);
    reset = 1'b0;
    cyc_wait(3);
    rd_chk("mid_level", 8'h00, 32'h0);
    rd_chk("mid_event", 8'h04, 32'h0);
    rd_chk("mid_mask",  8'h08, 32'h0);
    rd_chk("mid_cfg",   8'h0C, 32'h4);
    chk("mid_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    wr(8'h08, 32'h080);
    cyc_wait(6);
    rd_chk("post_early_ev", 8'h04, 32'h000);
    rd_chk("post_early_lv", 8'h00, 32'h000);
    cyc_wait(40);
    rd_chk("post_event", 8'h04, 32'h080);
    rd_chk("post_level", 8'h00, 32'h080);
    chk("post_irq", {31'd0, irq}, 32'd1);

`ifdef KEYPORT_RELEASE_EVT_EN
    keys[7] = 1'b0;
    cyc_wait(40);
    wr(8'h04, 32'h3FF);
    wr(8'h10, 32'h3FF);
    wr(8'h08, 32'h001);
    rd_chk("rel_clr", 8'h10, 32'h000);
    keys[0] = 1'b1; cyc_wait(40);
    keys[0] = 1'b0; cyc_wait(40);
    rd_chk("pr_event", 8'h04, 32'h001);
    rd_chk("pr_rel",   8'h10, 32'h001);
    chk("pr_irq", {31'd0, irq}, 32'd1);
    wr(8'h04, 32'h001);
    chk("irq_rel_hold", {31'd0, irq}, 32'd1);
    wr(8'h10, 32'h001);
    chk("irq_rel_clr", {31'd0, irq}, 32'd0);
    rd_chk("rel_zero", 8'h10, 32'h000);
`else
    wr(8'h10, 32'h3FF);
    rd_chk("no_rel_reg", 8'h10, 32'h000);
    chk("no_rel_irq", {31'd0, irq}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
